// File: rtl/sw_array_scheduler_if.sv
// Bundle between the SW array scheduler, the upstream base stream, PE 0, the last PE and the result sink.
interface sw_array_scheduler_if #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 4
);
    logic                   tgt_valid;
    logic [1:0]             tgt_data;
    logic                   tgt_last;
    logic                   tgt_ready;
    logic                   pe_en;
    logic                   pe_toggle;
    logic [1:0]             pe_data;
    logic [SCORE_WIDTH-1:0] pe_bound;
    logic [SCORE_WIDTH-1:0] last_high;
    logic                   last_vld0;
    logic                   last_vld1;
    logic                   res_valid;
    logic                   res_ready;
    logic [SCORE_WIDTH-1:0] res_score;
    logic [ID_WIDTH-1:0]    res_id;
    logic                   res_toggle;
    logic                   err_bubble;
    logic                   err_spurious;
    logic                   busy;

    modport master (
        input  tgt_valid, tgt_data, tgt_last, last_high, last_vld0, last_vld1, res_ready,
        output tgt_ready, pe_en, pe_toggle, pe_data, pe_bound, res_valid, res_score,
        output res_id, res_toggle, err_bubble, err_spurious, busy
    );

    modport slave (
        output tgt_valid, tgt_data, tgt_last, last_high, last_vld0, last_vld1, res_ready,
        input  tgt_ready, pe_en, pe_toggle, pe_data, pe_bound, res_valid, res_score,
        input  res_id, res_toggle, err_bubble, err_spurious, busy
    );
endinterface

// File: rtl/sw_array_scheduler.sv
// Feeds target sequences into a Smith-Waterman PE chain, alternating toggles, and collects final scores.
//   state  | meaning
//   IDLE   | waiting for a target and a free toggle slot
//   STREAM | forwarding bases to PE 0
//   GAP    | one enable-low cycle before the toggle may flip
module sw_array_scheduler #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    sw_array_scheduler_if.master bus
);
    localparam logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t                 state, state_nxt;
    logic                   last_tog, out_tog, nt;
    logic [ID_WIDTH-1:0]    id_cnt;
    logic [1:0]             inflight, inflight_nxt, slot_full, slot_full_nxt, vld;
    logic [ID_WIDTH-1:0]    tag [2];
    logic [SCORE_WIDTH-1:0] slot_score [2];
    logic                   issue, beat, bubble, accept;

    assign nt     = ~last_tog;
    assign vld    = {bus.last_vld1, bus.last_vld0};
    assign issue  = (state == IDLE) && bus.tgt_valid && !inflight[nt] && !slot_full[nt];
    assign beat   = (state == STREAM) && bus.tgt_valid;
    assign bubble = (state == STREAM) && !bus.tgt_valid;
    assign accept = bus.res_valid && bus.res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = STREAM;
            STREAM:  if (bubble || bus.tgt_last) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tgt_ready = (state == STREAM);
    end

    // A slot cannot be captured and re-issued together: issue needs it idle, capture needs it in flight.
    always_comb begin
        inflight_nxt  = inflight;
        slot_full_nxt = slot_full;
        if (vld[0] && inflight[0]) begin
            inflight_nxt[0]  = 1'b0;
            slot_full_nxt[0] = 1'b1;
        end
        if (vld[1] && inflight[1]) begin
            inflight_nxt[1]  = 1'b0;
            slot_full_nxt[1] = 1'b1;
        end
        if (issue)  inflight_nxt[nt]        = 1'b1;
        if (accept) slot_full_nxt[out_tog] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.pe_en        <= 1'b0;
            bus.pe_data      <= 2'b00;
            bus.pe_toggle    <= 1'b1;
            last_tog         <= 1'b1;
            out_tog          <= 1'b0;
            id_cnt           <= '0;
            inflight         <= 2'b00;
            slot_full        <= 2'b00;
            tag[0]           <= '0;
            tag[1]           <= '0;
            slot_score[0]    <= '0;
            slot_score[1]    <= '0;
            bus.err_bubble   <= 1'b0;
            bus.err_spurious <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.pe_en   <= beat;
            bus.pe_data <= beat ? bus.tgt_data : 2'b00;
            if (issue) begin
                bus.pe_toggle <= nt;
                last_tog      <= nt;
                tag[nt]       <= id_cnt;
                id_cnt        <= id_cnt + 1'b1;
            end
            if (vld[0] && inflight[0]) slot_score[0] <= bus.last_high - ZERO;
            if (vld[1] && inflight[1]) slot_score[1] <= bus.last_high - ZERO;
            if (accept) out_tog <= ~out_tog;
            inflight  <= inflight_nxt;
            slot_full <= slot_full_nxt;
            if (bubble) bus.err_bubble <= 1'b1;
            if (|(vld & ~inflight)) bus.err_spurious <= 1'b1;
            bus.busy <= (state_nxt != IDLE) || (|inflight_nxt) || (|slot_full_nxt);
        end
    end

    // A slot's tag is only rewritten on issue, which requires the slot to be empty.
    assign bus.res_valid  = slot_full[out_tog];
    assign bus.res_score  = slot_score[out_tog];
    assign bus.res_id     = tag[out_tog];
    assign bus.res_toggle = out_tog;
    assign bus.pe_bound   = ZERO;
endmodule

// File: doc/sw_array_scheduler.md
# sw_array_scheduler

Sequencing controller for a linear chain of Smith-Waterman processing elements (PEs). It accepts target sequences from an upstream base stream and drives the first PE's data, enable and toggle inputs. It alternates the toggle between back-to-back sequences so that two alignments can be in flight, and captures the final high score from the last PE into a handshaked result port.

## Interface
- SCORE_WIDTH, 12, score width; biased zero ZERO = 2^(SCORE_WIDTH-1)
- ID_WIDTH, 4, sequence tag width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tgt_valid  in  1  target base available
- tgt_data  in  2  target base (A=00, G=01, T=10, C=11)
- tgt_last  in  1  marks final base of a sequence
- tgt_ready  out  1  base accepted when tgt_valid & tgt_ready
- pe_en  out  1  enable to PE 0 (en_in)
- pe_toggle  out  1  toggle to PE 0 (toggle_in)
- pe_data  out  2  base to PE 0 (data_in)
- pe_bound  out  SCORE_WIDTH  constant ZERO; drives M_in, I_in and High_in of PE 0
- last_high  in  SCORE_WIDTH  High_out of last PE
- last_vld0, last_vld1  in  1  vld0/vld1 of last PE, one-cycle pulses
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_score  out  SCORE_WIDTH  unbiased score = captured high − ZERO
- res_id  out  ID_WIDTH  tag of the sequence the result belongs to
- res_toggle  out  1  toggle used by that sequence
- err_bubble, err_spurious  out  1  sticky error flags
- busy  out  1  any sequence streaming or in flight

## Operation
- Reset values: tgt_ready=0, pe_en=0, pe_toggle=1, pe_data=00, res_valid=0, res_score=0, res_id=0, res_toggle=0, both err flags=0, busy=0.
- Internal reset state: state=IDLE, last_tog=1, out_tog=0, id_cnt=0, inflight[1:0]=0, slot_full[1:0]=0.
- FSM states: IDLE, STREAM, GAP.
- IDLE
  - nt = ~last_tog.
  - Transition to STREAM when tgt_valid & !inflight[nt] & !slot_full[nt].
  - On that transition: pe_toggle<=nt, last_tog<=nt, inflight[nt]<=1, tag[nt]<=id_cnt, id_cnt<=id_cnt+1 (wraps).
  - tgt_ready=0 in IDLE.
- STREAM
  - tgt_ready=1.
  - Each accepted beat: pe_en<=1, pe_data<=tgt_data.
  - Beat with tgt_last: go to GAP.
  - Cycle with tgt_valid=0: pe_en<=0, err_bubble<=1, go to GAP. The sequence is truncated; its result is still collected.
- GAP: pe_en=0, pe_data=00, pe_toggle unchanged for exactly one cycle, then IDLE. This guarantees every PE sees en low under the old toggle before the toggle flips.
- Capture
  - last_vld{t} pulse with inflight[t]=1: slot[t]<=last_high−ZERO, slot_full[t]<=1, inflight[t]<=0.
  - Pulse with inflight[t]=0: ignored, err_spurious<=1.
- Output
  - res_valid = slot_full[out_tog]; res_score, res_id and res_toggle come from slot[out_tog].
  - On accept: slot_full[out_tog]<=0, out_tog<=~out_tog.
  - Results therefore leave in issue order.
- At most two sequences outstanding, one per toggle. A third issue waits in IDLE until its toggle's result is accepted.
- Arithmetic: subtraction is modulo 2^SCORE_WIDTH. last_high below ZERO is not checked.
- busy = (state≠IDLE) | inflight[0] | inflight[1] | slot_full[0] | slot_full[1].

## Timing
- All outputs are registered, except tgt_ready, res_valid and the res_* fields (decoded from registered state).
- Beat accepted at cycle k → pe_en=1 with that base at k+1.
- Sequence length L: pe_en high for L consecutive cycles, then at least 1 low cycle.
- Minimum interval between consecutive sequence starts: L+2 cycles (stream, GAP, IDLE).
- last_vld{t} at cycle c → res_valid at c+1 if out_tog=t.
- Simultaneous capture on slot t and accept on slot ~t: both take effect.
- Simultaneous last_vld0 and last_vld1: both captured.
- Issue check uses registered flags, so a slot freed at cycle c enables an issue at c+1 at the earliest.
- Reset asserted mid-stream: all state clears asynchronously and pe_en drops immediately. The PE chain must share the same reset.

## Test plan
- Single sequence of 5 bases: pe_en high 5 cycles with toggle=0, then GAP. Pulse last_vld0 with last_high=0x80A → res_valid, res_score=10, res_id=0, res_toggle=0.
- Two back-to-back sequences (L=3, L=4): second streams with toggle=1 starting 5 cycles after the first. Return vld1 before vld0 → results still emitted id 0 then id 1.
- Third sequence while both slots are unread: stays in IDLE with tgt_ready=0. Accept result 0 → issue with toggle=0 at the earliest the cycle after.
- tgt_valid drops for 1 cycle mid-stream → err_bubble=1, pe_en low, GAP, truncated result still returned.
- last_vld1 with nothing in flight → err_spurious=1, res_valid stays 0.
- Reset asserted during STREAM → all outputs return to reset values without a clock edge. id_cnt restarts at 0; 16 issues after reset wrap res_id back to 0.
